// File: rtl/ttt_pkg.sv
// ============================================================================
// Module      : ttt_pkg
// Description : Shared cell/result encodings and FSM states for the
//               tic-tac-toe board controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ttt_pkg;

    localparam int NUM_CELLS = 9;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_X    = 2'b01;
    localparam logic [1:0] RES_O    = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_CHECK = 2'd1,
        ST_OVER  = 2'd2
    } ttt_state_e;

endpackage

`default_nettype wire

// File: rtl/ttt_board_ctrl_if.sv
// ============================================================================
// Module      : ttt_board_ctrl_if
// Description : Move handshake, line-checker result and board/status bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ttt_board_ctrl_if;
    import ttt_pkg::*;

    logic                     new_game;
    logic                     move_valid;
    logic [3:0]               move_pos;
    logic                     move_ready;
    logic [1:0]               win_in;
    logic [2*NUM_CELLS-1:0]   board;
    logic                     turn;
    logic                     illegal;
    logic                     game_over;
    logic [1:0]               result;
    logic [3:0]               move_cnt;

    modport master (
        output new_game, move_valid, move_pos, win_in,
        input  move_ready, board, turn, illegal, game_over, result, move_cnt
    );

    modport slave (
        input  new_game, move_valid, move_pos, win_in,
        output move_ready, board, turn, illegal, game_over, result, move_cnt
    );

endinterface

`default_nettype wire

// File: rtl/ttt_move_timer.sv
// ============================================================================
// Module      : ttt_move_timer
// Description : Per-move idle counter; flags expiry after TIMEOUT_CYCLES in PLAY.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ttt_move_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // Saturates at the last value so a rejected move at expiry re-arms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (run && (r_cnt != C_LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expire = run && (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/ttt_board_ctrl.sv
// ============================================================================
// Module      : ttt_board_ctrl
// Description : Tic-tac-toe game-state controller; optional move timeout
//               enabled by defining TTT_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ttt_board_ctrl
    import ttt_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    ttt_board_ctrl_if.slave   bus
);

    localparam logic [1:0] S_PLAY  = ST_PLAY;
    localparam logic [1:0] S_CHECK = ST_CHECK;
    localparam logic [1:0] S_OVER  = ST_OVER;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("ttt_board_ctrl: TIMEOUT_CYCLES must be at least 2");
    end

    logic [1:0]             r_state;
    logic [2*NUM_CELLS-1:0] r_board;
    logic                   r_turn;
    logic                   r_illegal;
    logic [1:0]             r_result;
    logic [3:0]             r_move_cnt;

    logic       w_transfer;
    logic       w_pos_ok;
    logic [3:0] w_idx;
    logic [1:0] w_cell;
    logic       w_legal;
    logic       w_expire;

    assign bus.move_ready = (r_state == S_PLAY) && !bus.new_game;
    assign w_transfer     = bus.move_valid && bus.move_ready;
    assign w_pos_ok       = (bus.move_pos < 4'(NUM_CELLS));
    // Out-of-range positions are redirected to cell 0 so the read stays in bounds.
    assign w_idx          = w_pos_ok ? bus.move_pos : 4'd0;
    assign w_cell         = r_board[{w_idx, 1'b0} +: 2];
    assign w_legal        = w_pos_ok && (w_cell == CELL_EMPTY);

`ifdef TTT_TIMEOUT_EN
    ttt_move_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_move_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (r_state == S_PLAY),
        .clear  (bus.new_game || (w_transfer && w_legal)),
        .expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_PLAY;
            r_board    <= '0;
            r_turn     <= 1'b0;
            r_illegal  <= 1'b0;
            r_result   <= RES_NONE;
            r_move_cnt <= 4'd0;
        end else if (bus.new_game) begin
            r_state    <= S_PLAY;
            r_board    <= '0;
            r_turn     <= 1'b0;
            r_illegal  <= 1'b0;
            r_result   <= RES_NONE;
            r_move_cnt <= 4'd0;
        end else begin
            r_illegal <= 1'b0;
            case (r_state)
                S_PLAY: begin
                    if (w_transfer) begin
                        if (w_legal) begin
                            r_board[{w_idx, 1'b0} +: 2] <= r_turn ? CELL_O : CELL_X;
                            r_move_cnt <= r_move_cnt + 4'd1;
                            r_state    <= S_CHECK;
                        end else begin
                            r_illegal <= 1'b1;
                        end
                    end else if (w_expire) begin
                        // The player to move forfeits, so the other side wins.
                        r_result <= r_turn ? RES_X : RES_O;
                        r_state  <= S_OVER;
                    end
                end
                S_CHECK: begin
                    if (bus.win_in[0]) begin
                        r_result <= RES_X;
                        r_state  <= S_OVER;
                    end else if (bus.win_in[1]) begin
                        r_result <= RES_O;
                        r_state  <= S_OVER;
                    end else if (r_move_cnt == 4'(NUM_CELLS)) begin
                        r_result <= RES_DRAW;
                        r_state  <= S_OVER;
                    end else begin
                        r_turn  <= ~r_turn;
                        r_state <= S_PLAY;
                    end
                end
                S_OVER: begin
                end
                default: begin
                    r_state <= S_PLAY;
                end
            endcase
        end
    end

    assign bus.board     = r_board;
    assign bus.turn      = r_turn;
    assign bus.illegal   = r_illegal;
    assign bus.game_over = (r_state == S_OVER);
    assign bus.result    = r_result;
    assign bus.move_cnt  = r_move_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ttt_board_ctrl.sv
// ============================================================================
// Module      : tb_ttt_board_ctrl
// Description : Directed and random checks of ttt_board_ctrl against a
//               game-rule model; timeout checks when TTT_TIMEOUT_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ttt_board_ctrl;
    import ttt_pkg::*;

    localparam int TO = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ttt_board_ctrl_if bus();

    ttt_board_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Game model: phase 0 = waiting for a move, 1 = judging, 2 = finished.
    int m_cell [9];
    int m_turn, m_cnt, m_res, m_phase, m_ill, m_idle;
    int n_assert = 0;
    int n_fail   = 0;
    int force_win = -1;

    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    function automatic logic [1:0] line_win();
        logic [1:0] w = 2'b00;
        for (int l = 0; l < 8; l++) begin
            int a = m_cell[lines[l][0]];
            if (a != 0 && a == m_cell[lines[l][1]] && a == m_cell[lines[l][2]])
                w[a-1] = 1'b1;
        end
        return w;
    endfunction

    function automatic logic [17:0] packed_board();
        logic [17:0] b = '0;
        for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(m_cell[i]);
        return b;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 9; i++) m_cell[i] = 0;
        m_turn = 0; m_cnt = 0; m_res = 0; m_phase = 0; m_ill = 0; m_idle = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("board",     32'(bus.board),     32'(packed_board()));
        chk("turn",      32'(bus.turn),      32'(m_turn));
        chk("illegal",   32'(bus.illegal),   32'(m_ill));
        chk("game_over", 32'(bus.game_over), 32'(m_phase == 2));
        chk("result",    32'(bus.result),    32'(m_res));
        chk("move_cnt",  32'(bus.move_cnt),  32'(m_cnt));
    endtask

    task automatic model_step(input logic v, input logic [3:0] p, input logic ng,
                              input logic [1:0] w);
        int pi = int'(p);
        m_ill = 0;
        if (ng) begin
            reset_model();
        end else if (m_phase == 0) begin
            if (v) begin
                if (pi <= 8 && m_cell[pi] == 0) begin
                    m_cell[pi] = m_turn + 1;
                    m_cnt++;
                    m_phase = 1;
                    m_idle = 0;
                end else begin
                    m_ill = 1;
                    if (m_idle < TO - 1) m_idle++;
                end
            end else begin
`ifdef TTT_TIMEOUT_EN
                if (m_idle == TO - 1) begin
                    m_res = (m_turn == 0) ? 2 : 1;
                    m_phase = 2;
                end else begin
                    m_idle++;
                end
`else
                m_idle++;
`endif
            end
        end else if (m_phase == 1) begin
            if (w[0])            begin m_res = 1; m_phase = 2; end
            else if (w[1])       begin m_res = 2; m_phase = 2; end
            else if (m_cnt == 9) begin m_res = 3; m_phase = 2; end
            else                 begin m_turn ^= 1; m_phase = 0; end
        end
    endtask

    // Entered and left at a falling edge.
    task automatic cycle(input logic v, input logic [3:0] p, input logic ng);
        bus.move_valid = v;
        bus.move_pos   = p;
        bus.new_game   = ng;
        if (force_win >= 0)    bus.win_in = 2'(force_win);
        else if (m_phase == 1) bus.win_in = line_win();
        else                   bus.win_in = 2'($urandom);
        #1;
        chk("move_ready", 32'(bus.move_ready), 32'(m_phase == 0 && !ng));
        @(posedge clk);
        model_step(v, p, ng, bus.win_in);
        @(negedge clk);
        check_all();
    endtask

    task automatic move(input logic [3:0] p);
        cycle(1'b1, p, 1'b0);
        cycle(1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        bus.new_game = 1'b0; bus.move_valid = 1'b0; bus.move_pos = 4'd0; bus.win_in = 2'b00;
        reset_model();
        repeat (2) @(negedge clk);
        check_all();
        chk("reset_ready", 32'(bus.move_ready), 32'd1);
        rst_n = 1'b1;

        // X wins on the diagonal 0-4-8
        move(0); move(1); move(4); move(2); move(8);
        chk("win_result", 32'(bus.result), 32'(RES_X));
        chk("win_cnt", 32'(bus.move_cnt), 32'd5);
        cycle(1'b1, 4'd3, 1'b0);
        cycle(1'b0, 4'd0, 1'b1);

        // rejected moves: occupied cell, then out of range
        move(4);
        cycle(1'b1, 4'd4, 1'b0);
        chk("illegal_occ", 32'(bus.illegal), 32'd1);
        cycle(1'b0, 4'd0, 1'b0);
        cycle(1'b1, 4'd12, 1'b0);
        chk("illegal_range", 32'(bus.illegal), 32'd1);
        cycle(1'b0, 4'd0, 1'b0);
        cycle(1'b0, 4'd0, 1'b1);

        // full-board draw
        move(0); move(1); move(2); move(4); move(3); move(5); move(7); move(6); move(8);
        chk("draw_result", 32'(bus.result), 32'(RES_DRAW));
        chk("draw_cnt", 32'(bus.move_cnt), 32'd9);
        cycle(1'b1, 4'd0, 1'b0);
        cycle(1'b0, 4'd0, 1'b1);

        // new_game beats a simultaneous move
        move(0); move(4);
        cycle(1'b1, 4'd8, 1'b1);
        chk("ng_board", 32'(bus.board), 32'd0);

        // both win bits set resolve as an X win
        cycle(1'b1, 4'd0, 1'b0);
        force_win = 3;
        cycle(1'b0, 4'd0, 1'b0);
        force_win = -1;
        chk("both_win", 32'(bus.result), 32'(RES_X));
        cycle(1'b0, 4'd0, 1'b1);

        // asynchronous reset during the judging cycle
        cycle(1'b1, 4'd4, 1'b0);
        bus.move_valid = 1'b0;
        bus.win_in = 2'b01;
        rst_n = 1'b0;
        #1;
        reset_model();
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        cycle(1'b1, 4'd0, 1'b0);
        chk("post_reset_cnt", 32'(bus.move_cnt), 32'd1);
        cycle(1'b0, 4'd0, 1'b1);

`ifdef TTT_TIMEOUT_EN
        repeat (TO) cycle(1'b0, 4'd0, 1'b0);
        chk("timeout_result", 32'(bus.result), 32'(RES_O));
        chk("timeout_over", 32'(bus.game_over), 32'd1);
        cycle(1'b0, 4'd0, 1'b1);
        repeat (TO - 1) cycle(1'b0, 4'd0, 1'b0);
        cycle(1'b1, 4'd0, 1'b0);
        chk("expiry_transfer", 32'(bus.game_over), 32'd0);
        cycle(1'b0, 4'd0, 1'b1);
`endif

        // random play
        for (int n = 0; n < 1500; n++) begin
            logic       v  = ($urandom_range(0, 2) != 0);
            logic [3:0] p  = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 8))
                                                         : 4'($urandom_range(0, 15));
            logic       ng = (m_phase == 2) ? ($urandom_range(0, 3) == 0)
                                            : ($urandom_range(0, 59) == 0);
            cycle(v, p, ng);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ttt_board_ctrl.md
# ttt_board_ctrl

Game-state controller for the tic-tac-toe datapath: holds the 3x3 board, accepts player moves through a valid/ready handshake, and alternates turns. It sits directly upstream of the line checkers. It drives the flattened board to the eight `pos_win` line-checker instances and samples their OR-combined `winner` result to decide win, draw or continue.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1000: per-move time limit; used only when `TTT_TIMEOUT_EN` is defined.

Ports:
- `clk`, input, 1: single clock; all state on rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `new_game`, input, 1: synchronous restart request, level-sampled.
- `move_valid`, input, 1: a move is offered.
- `move_pos`, input, 4: cell index 0..8, row-major (cell r*3+c).
- `move_ready`, output, 1: the controller can accept a move.
- `win_in`, input, 2: OR of all eight line-checker `winner` outputs; bit0 = X wins, bit1 = O wins.
- `board`, output, 18: cell i occupies bits [2i+1:2i]. Encoding: 00 empty, 01 X, 10 O.
- `turn`, output, 1: 0 = X to move, 1 = O to move.
- `illegal`, output, 1: one-cycle pulse when a move is rejected.
- `game_over`, output, 1: high while in OVER.
- `result`, output, 2: 00 none, 01 X won, 10 O won, 11 draw.
- `move_cnt`, output, 4: number of accepted moves, 0..9.

## Operation
- FSM states are PLAY, CHECK and OVER. Reset state is PLAY.
- Reset values: board all 0, turn 0, move_cnt 0, result 00, illegal 0, game_over 0, move_ready 1.
- `move_ready` equals (state==PLAY) and not `new_game`. A transfer occurs when `move_valid` and `move_ready` are both high.
- Transfer in PLAY with a legal move:
  - A legal move has `move_pos`<=8 and a target cell equal to 00.
  - The cell is written with 01 if turn=0, or 10 if turn=1.
  - move_cnt increments, and the FSM goes to CHECK.
- Transfer in PLAY with an illegal move:
  - An illegal move has `move_pos`>=9 or an occupied target cell.
  - `illegal` pulses for one cycle. Board, turn and move_cnt are unchanged, and the FSM stays in PLAY.
- CHECK lasts exactly one cycle, and `win_in` is sampled there against the registered board. Outcomes, in priority order:
  - win_in[0]=1: result 01, go to OVER.
  - otherwise win_in[1]=1: result 10, go to OVER.
  - otherwise move_cnt==9: result 11, go to OVER.
  - otherwise turn toggles and the FSM returns to PLAY.
- `win_in`=11 therefore resolves as an X win.
- OVER holds board, result and move_cnt until `new_game`. Moves are not accepted in OVER, and `illegal` stays low.
- `new_game` in any state: on the next edge the controller restores the reset values (state PLAY). It has priority over a simultaneous move, and `move_ready` is low in that cycle so no transfer occurs.
- `win_in` is ignored outside CHECK.

## Timing
- Accepted move: the board is updated at edge N+1; CHECK is active in cycle N+1; result or turn is updated at edge N+2; `move_ready` is high again in cycle N+2 if play continues.
- Peak throughput is one move per 2 cycles.
- `illegal` is asserted in the cycle after the offending transfer, for exactly one cycle.
- `game_over` and `result` change at the same edge.
- Asserting `rst_n` mid-game clears everything asynchronously. The first move may be accepted in the first cycle after deassertion.

## Configuration
- `TTT_TIMEOUT_EN` defined:
  - A per-move counter runs in PLAY. It clears on each accepted move, on `new_game`, and on reset. Illegal moves do not clear it.
  - When the counter reaches TIMEOUT_CYCLES-1 with no transfer, the player to move forfeits: result becomes 10 if turn=0 or 01 if turn=1, and the FSM goes to OVER.
  - A transfer in the same cycle as expiry wins; the timeout is ignored.
- `TTT_TIMEOUT_EN` undefined: there is no counter and no forfeit. `TIMEOUT_CYCLES` is unused.

## Structure
- Package `ttt_pkg` holds:
  - cell encoding constants: CELL_EMPTY, CELL_X, CELL_O;
  - result codes: RES_NONE, RES_X, RES_O, RES_DRAW;
  - the FSM state enum;
  - the constant NUM_CELLS = 9.
- Sub-module `ttt_move_timer` holds the timeout counter and is instantiated only under `TTT_TIMEOUT_EN`.
- The eight `pos_win` instances and their OR live in the parent, outside this block.

## Test plan
- X plays cells 0, 4, 8 and O plays 1, 2, with `win_in` driven from a line-check model: result=01 and game_over=1 at the edge after the CHECK that follows X's third move; move_cnt=5.
- Move to an occupied cell 4, then to `move_pos`=12: `illegal` pulses once for each; board, turn and move_cnt are unchanged; `move_ready` stays 1.
- Full draw sequence X:0,2,3,7,8 and O:1,4,5,6 with `win_in`=00: after the 9th move, result=11 and move_cnt=9; any further `move_valid` is not accepted.
- `new_game` asserted together with `move_valid` in PLAY mid-game: no transfer occurs; the next cycle shows board 0, turn 0, result 00.
- `rst_n` pulsed low during CHECK: all outputs return to their reset values immediately, with no result latched.
- With `TTT_TIMEOUT_EN` and TIMEOUT_CYCLES=8, X idle for 8 cycles: result=10 and game_over=1. A second run with a transfer in the expiry cycle shows no forfeit.
